// File: rtl/rr_load_arbiter.sv
// Round-robin load scheduler: grants one requester at a time onto a shared
// capture register and holds the captured word valid for HOLD cycles.
//
// state | meaning
// IDLE  | waiting for any REQ; arbitrates from ptr at the exit edge
// LOAD  | one cycle, GNT/LOAD high; capture happens at the closing edge
// HOLD  | Q valid, counting down HOLD cycles before returning to IDLE
module rr_load_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 4,
   parameter int HOLD = 2,
   parameter int IW   = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   REQ,
   input  logic [NREQ*W-1:0] D,
   output logic [NREQ-1:0]   GNT,
   output logic              LOAD,
   output logic [W-1:0]      Q,
   output logic [IW-1:0]     OWNER,
   output logic              VALID,
   output logic              BUSY
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_HOLD} state_t;

   state_t        state;
   logic [IW-1:0] ptr;
   logic [3:0]    cnt;
   logic [IW-1:0] sel;
   logic          found;
   logic [IW:0]   idx;
   logic [W-1:0]  d_slice [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign d_slice[i] = D[i*W +: W];
   end

   // Scan offsets from high to low so the requester closest to ptr wins last.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = {1'b0, ptr} + (IW+1)'(k);
         if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
         if (REQ[idx[IW-1:0]]) begin
            sel   = idx[IW-1:0];
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
         ptr   <= '0;
         cnt   <= '0;
         GNT   <= '0;
         LOAD  <= 1'b0;
         Q     <= '0;
         OWNER <= '0;
         VALID <= 1'b0;
         BUSY  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found) begin
                  state <= ST_LOAD;
                  GNT   <= NREQ'(1) << sel;
                  OWNER <= sel;
                  LOAD  <= 1'b1;
                  BUSY  <= 1'b1;
               end
            end
            ST_LOAD: begin
               Q     <= d_slice[OWNER];
               VALID <= 1'b1;
               if (OWNER == IW'(NREQ - 1)) ptr <= '0;
               else                        ptr <= OWNER + 1'b1;
               cnt   <= 4'(HOLD - 1);
               GNT   <= '0;
               LOAD  <= 1'b0;
               state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= ST_IDLE;
                  VALID <= 1'b0;
                  BUSY  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               GNT   <= '0;
               LOAD  <= 1'b0;
               VALID <= 1'b0;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/rr_load_arbiter.md
Name: rr_load_arbiter

Overview:
- Round-robin controller that shares one W-bit capture register (edge-triggered, positive-edge load) between NREQ requesters.
- Each requester presents a W-bit data word and a request. The block grants one requester at a time, sequences the load, and holds the captured value valid for a fixed number of cycles.
- Sits in front of the lab's 4-bit register datapath as its load scheduler.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, data width per requester and of the capture register
- HOLD, 2, cycles VALID stays high after a capture (1..15)
- IW, 2, owner index width, must equal ceil(log2(NREQ))

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  synchronous active-high reset
- REQ  input  NREQ  per-requester request, level-sensitive
- D  input  NREQ*W  packed data; requester i occupies bits [i*W+W-1 : i*W]
- GNT  output  NREQ  registered one-hot grant; zero when not in LOAD
- LOAD  output  1  capture-enable strobe, high only in LOAD state
- Q  output  W  captured data word
- OWNER  output  IW  index of the requester whose data is in Q
- VALID  output  1  Q is fresh; high exactly HOLD cycles per capture
- BUSY  output  1  high in LOAD and HOLD states

Behaviour:
- Reset (RST=1 at a rising edge):
  - state<=IDLE, PTR<=0, hold counter<=0.
  - GNT=0, LOAD=0, Q=0, OWNER=0, VALID=0, BUSY=0.
  - Reset has priority over every other event.
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise select sel = first index i, scanning PTR, PTR+1, ... modulo NREQ, with REQ[i]=1.
  - Next state LOAD; GNT<=onehot(sel); OWNER<=sel.
- LOAD (exactly 1 cycle):
  - LOAD=1, BUSY=1, GNT held.
  - At the closing edge: Q<=D slice of OWNER sampled that edge; VALID<=1; PTR<=OWNER+1, wrapping NREQ-1 -> 0; counter<=HOLD-1; GNT<=0; next state HOLD.
- HOLD:
  - VALID=1, BUSY=1, GNT=0.
  - While counter!=0, decrement. When counter==0, next state IDLE with VALID<=0 and BUSY<=0.
- Timing, with REQ sampled at the edge ending IDLE cycle n:
  - GNT and LOAD are high in cycle n+1.
  - Q, OWNER and VALID are valid from cycle n+2 through n+1+HOLD.
  - IDLE in cycle n+2+HOLD.
  - Minimum capture period is HOLD+2 cycles.
- The IDLE cycle is mandatory. No direct HOLD->LOAD transition.
- A grant is committed once LOAD is entered. A requester dropping REQ during LOAD still has its data captured. A requester must hold its D stable while its GNT is high.
- REQ changes during HOLD are ignored. Arbitration uses REQ only at the IDLE-exit edge.
- Q and OWNER retain their last values after VALID falls, until the next capture or reset.
- Fairness: with all REQ high continuously, grants rotate 0,1,...,NREQ-1,0,... No requester waits more than NREQ captures.
- Reset mid-LOAD or mid-HOLD aborts the operation. All outputs go to reset values at that edge and no capture occurs.
- Out-of-range requester indices cannot be produced. OWNER is always < NREQ.

Test Plan:
- Single requester: NREQ=4, HOLD=2, REQ=0100, D slice 2 = 4'hA, cycle n in IDLE.
  - Expect GNT=0100 and LOAD=1 in n+1.
  - Expect Q=4'hA, OWNER=2, VALID=1 in n+2..n+3.
  - Expect VALID=0 and IDLE in n+4.
- Contention: REQ=1111 held, D slices = 4'h1, 4'h2, 4'h3, 4'h4.
  - Expect OWNER sequence 0,1,2,3,0 with Q = 1,2,3,4,1.
  - Expect a new LOAD every 4 cycles.
- Pointer wrap: last grant to 3, then REQ=1001.
  - Expect next grant to 0 (PTR wrapped), then to 3.
- Drop during grant: REQ=0010, deassert REQ in the LOAD cycle.
  - Expect Q = D slice 1 and VALID high for 2 cycles regardless.
- Reset mid-operation: assert RST during the LOAD cycle with Q previously 4'h7.
  - Expect GNT=0, Q=0, VALID=0, BUSY=0 next cycle.
  - Expect the following grant to go to requester 0 when REQ=1111.
- HOLD=1 and idle: with HOLD=1, expect VALID high exactly 1 cycle and a 3-cycle capture period.
  - With REQ=0 for 20 cycles, expect GNT=0, LOAD=0, BUSY=0 and Q unchanged throughout.
